// File: rtl/aes_wrap_pkg.sv
// Shared definitions for the AES word-stream wrapper.
// Contents:
//   - WORD_W / WORDS_PER_BLOCK / BLOCK_W : stream and block geometry
//   - word_idx_t                         : 2-bit word index within a block
//   - state_t                            : control FSM states
//   - get_word / put_word                : word index <-> 128-bit slice helpers
//     (word 0 lives in bits [127:96])
package aes_wrap_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

  typedef logic [1:0] word_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    TEXT,
    LOAD,
    WAIT,
    DRAIN
  } state_t;

  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input word_idx_t idx);
    return blk[BLOCK_W-1-WORD_W*int'(idx) -: WORD_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input word_idx_t idx,
                                                  input logic [WORD_W-1:0] w);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[BLOCK_W-1-WORD_W*int'(idx) -: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/aes_block_serializer.sv
// Holds a captured 128-bit ciphertext block and presents it as four 32-bit
// words on a valid/ready stream, word 0 (bits [127:96]) first.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture load_data and restart at word 0
//   load_data   : 128-bit block from the cipher core
//   valid       : stream valid, driven by the control FSM
//   ready       : downstream accept
//   data        : current word (stable while valid & !ready)
//   last        : high with the 4th word
//   done        : pulses on the handshake of the 4th word
module aes_block_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] load_data,
  input  logic         valid,
  input  logic         ready,
  output logic [31:0]  data,
  output logic         last,
  output logic         done
);
  import aes_wrap_pkg::*;

  logic [127:0] blk_reg;
  word_idx_t    idx_reg;
  logic         hs;

  assign hs = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_reg <= '0;
      idx_reg <= '0;
    end else if (load) begin
      blk_reg <= load_data;
      idx_reg <= '0;
    end else if (hs) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  assign data = get_word(blk_reg, idx_reg);
  assign last = valid && (idx_reg == 2'd3);
  assign done = hs && (idx_reg == 2'd3);

endmodule

// File: rtl/aes_word_stream_wrap.sv
// Stream adapter for a 128-bit AES core. Assembles key/plaintext from
// 32-bit input words, pulses ld, waits for done under a watchdog, and
// streams the ciphertext back as four 32-bit words.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   key_reuse                    : on the first word of a job, skip key words
//                                  and reuse the held key (only if one is held)
//   in_valid/in_ready/in_data    : input word stream (key words, then text)
//   aes_key/aes_text_in/aes_ld   : to the core
//   aes_done/aes_text_out        : from the core
//   out_valid/out_ready/out_data : ciphertext word stream
//   out_last                     : high with the 4th ciphertext word
//   busy                         : high outside IDLE
//   err_timeout                  : sticky, set when the core fails to answer
module aes_word_stream_wrap #(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_reuse,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [127:0]      aes_key,
  output logic [127:0]      aes_text_in,
  output logic              aes_ld,
  input  logic              aes_done,
  input  logic [127:0]      aes_text_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout
);
  import aes_wrap_pkg::*;

  state_t       state_reg, state_next;
  logic [127:0] key_reg, text_reg;
  word_idx_t    cnt_reg;
  logic         key_held_reg;
  logic         err_reg;
  logic [7:0]   wdog_reg;

  logic in_hs;
  logic reuse_path;
  logic wdog_expired;
  logic last_word;
  logic ser_done;
  logic ser_load;

  assign in_hs        = in_valid && in_ready;
  assign reuse_path   = key_reuse && key_held_reg;
  assign last_word    = (cnt_reg == 2'd3);
  // wdog_reg counts cycles since the ld pulse; the cycle in which it holds
  // TIMEOUT_CYCLES-1 is the last one in which done is still accepted.
  assign wdog_expired = (wdog_reg == 8'(TIMEOUT_CYCLES - 1));
  assign ser_load     = (state_reg == WAIT) && aes_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (in_hs) state_next = reuse_path ? TEXT : KEY;
      KEY:   if (in_hs && last_word) state_next = TEXT;
      TEXT:  if (in_hs && last_word) state_next = LOAD;
      LOAD:  state_next = WAIT;
      // done is checked first so a coincident expiry is not an error
      WAIT: begin
        if (aes_done)          state_next = DRAIN;
        else if (wdog_expired) state_next = IDLE;
      end
      DRAIN: if (ser_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; rst masks the stream controls during the reset cycle
  always_comb begin
    in_ready  = 1'b0;
    aes_ld    = 1'b0;
    out_valid = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      IDLE, KEY, TEXT: in_ready  = !rst;
      LOAD:            aes_ld    = !rst;
      DRAIN:           out_valid = !rst;
      default: ;
    endcase
  end

  // Datapath: word assembly, key bookkeeping, watchdog, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg      <= '0;
      text_reg     <= '0;
      cnt_reg      <= '0;
      key_held_reg <= 1'b0;
      err_reg      <= 1'b0;
      wdog_reg     <= '0;
    end else begin
      if (in_hs) begin
        cnt_reg <= cnt_reg + 2'd1;
        if (state_reg == KEY || (state_reg == IDLE && !reuse_path))
          key_reg <= put_word(key_reg, cnt_reg, in_data);
        else
          text_reg <= put_word(text_reg, cnt_reg, in_data);
        if (state_reg == KEY && last_word)
          key_held_reg <= 1'b1;
      end

      if (state_reg == LOAD)
        wdog_reg <= 8'd1;
      else if (state_reg == WAIT)
        wdog_reg <= wdog_reg + 8'd1;

      if (state_reg == WAIT && !aes_done && wdog_expired)
        err_reg <= 1'b1;
    end
  end

  assign aes_key     = key_reg;
  assign aes_text_in = text_reg;
  assign err_timeout = err_reg;

  aes_block_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (aes_text_out),
    .valid     (out_valid),
    .ready     (out_ready),
    .data      (out_data),
    .last      (out_last),
    .done      (ser_done)
  );

endmodule
